// File: rtl/nonce_result_tx_pkg.sv
// Shared constants, FSM encoding and byte-lane selection
// for the nonce result framer.
package nonce_result_tx_pkg;

  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_ADDR_W = 3;
  localparam int FRAME_BYTES = 5;
  localparam int FRAME_W     = 33;

  localparam logic [7:0] TAG_FOUND = 8'h4E;
  localparam logic [7:0] TAG_DONE  = 8'h44;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  // Byte 0 is the tag, bytes 1..4 the nonce MSB first
  function automatic logic [7:0] frame_byte(
    input logic [32:0] f,
    input logic [2:0]  idx
  );
    logic [7:0] b;
    unique case (idx)
      3'd0:    b = f[32] ? TAG_DONE : TAG_FOUND;
      3'd1:    b = f[31:24];
      3'd2:    b = f[23:16];
      3'd3:    b = f[15:8];
      default: b = f[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nonce_result_tx_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a
// registered occupancy count.
module sync_fifo #(
  parameter int WIDTH  = 33,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              do_wr, do_rd;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LVL);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_rd = rd_en && !empty;
  // A write into a full FIFO is fine when the head leaves this cycle
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_wr && !do_rd) level_d = level_q + 1'b1;
    if (do_rd && !do_wr) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/nonce_result_tx.sv
// Buffers miner results and frames each one as a tag
// byte plus a big-endian nonce for the serial TX path.
module nonce_result_tx
  import nonce_result_tx_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            new_result,
  input  logic            result_done,
  input  logic [31:0]     result_data,
  output logic [7:0]      tx_data,
  output logic            new_tx_data,
  input  logic            tx_busy,
  output logic [ADDR_W:0] fifo_level,
  output logic            overflow,
  input  logic            clear_ovf
);

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [7:0]         txd_q, txd_d;
  logic               ntx_q, ntx_d;
  logic               ovf_q, ovf_d;

  logic               pop, push_ok;
  logic               f_empty, f_full;
  logic [FRAME_W-1:0] f_head;

  assign pop     = (state_q == S_IDLE) && !f_empty;
  assign push_ok = new_result && (!f_full || pop);

  sync_fifo #(
    .WIDTH  (FRAME_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_ok),
    .wr_data ({result_done, result_data}),
    .rd_en   (pop),
    .rd_data (f_head),
    .empty   (f_empty),
    .full    (f_full),
    .level   (fifo_level)
  );

  // A drop in the same cycle as a clear still leaves the flag set
  always_comb begin
    ovf_d = ovf_q;
    if (clear_ovf) ovf_d = 1'b0;
    if (new_result && !push_ok) ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    txd_d   = txd_q;
    ntx_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!f_empty) begin
          frame_d = f_head;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          txd_d   = frame_byte(frame_q, idx_q);
          ntx_d   = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (idx_q == 3'(FRAME_BYTES-1)) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      txd_q   <= '0;
      ntx_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      txd_q   <= txd_d;
      ntx_q   <= ntx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx_data     = txd_q;
  assign new_tx_data = ntx_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_nonce_result_tx.sv
// Scoreboard bench: stimulus queues expected bytes,
// a negedge monitor checks every transmitted byte.
module tb_nonce_result_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_result;
  logic        result_done;
  logic [31:0] result_data;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        clear_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int n_strobe = 0;
  logic [7:0] exp_q[$];
  logic prev_ntx = 1'b0;

  always #10 clk = ~clk;

  nonce_result_tx dut (
    .clk         (clk),
    .rst         (rst),
    .new_result  (new_result),
    .result_done (result_done),
    .result_data (result_data),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .clear_ovf   (clear_ovf)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected frame: tag then nonce MSB first
  task automatic expect_frame(input logic done, input logic [31:0] d);
    exp_q.push_back(done ? 8'h44 : 8'h4E);
    exp_q.push_back(d[31:24]);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  task automatic push(input logic done, input logic [31:0] d,
                      input logic accepted);
    @(negedge clk);
    new_result  = 1'b1;
    result_done = done;
    result_data = d;
    if (accepted) expect_frame(done, d);
    @(negedge clk);
    new_result = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_drain_left"}, exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_strobes(input string nm, input int n);
    int k = 0;
    int t = 0;
    while (k < n && t < 200) begin
      @(negedge clk);
      t++;
      if (new_tx_data) k++;
    end
    chk({nm, "_strobe_wait"}, k, n);
  endtask

  always @(negedge clk) begin
    if (new_tx_data) begin
      n_strobe++;
      chk("strobe_width", prev_ntx, 1'b0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_byte: got %0h expected none", tx_data);
      end else begin
        chk("tx_byte", tx_data, exp_q.pop_front());
      end
    end
    prev_ntx = new_tx_data;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    rst = 1'b1;
    new_result = 1'b0;
    result_done = 1'b0;
    result_data = '0;
    tx_busy = 1'b0;
    clear_ovf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_new_tx", new_tx_data, 1'b0);
    chk("rst_level", fifo_level, 4'd0);
    chk("rst_ovf", overflow, 1'b0);

    // 1: single found nonce
    push(1'b0, 32'hDEADBEEF, 1'b1);
    wait_drain("t1", 100);
    chk("t1_level", fifo_level, 4'd0);

    // 2: exhausted range
    push(1'b1, 32'h0000FFFF, 1'b1);
    wait_drain("t2", 100);

    // 3: transmitter busy, one entry sits in the frame register
    tx_busy = 1'b1;
    s0 = n_strobe;
    push(1'b0, 32'h11223344, 1'b1);
    push(1'b1, 32'h55667788, 1'b1);
    push(1'b0, 32'h99AABBCC, 1'b1);
    repeat (94) @(negedge clk);
    chk("t3_no_strobe", n_strobe - s0, 0);
    chk("t3_level", fifo_level, 4'd2);
    tx_busy = 1'b0;
    wait_drain("t3", 200);

    // 4: overflow; 1 held + 8 queued, the 10th is dropped
    tx_busy = 1'b1;
    for (int i = 0; i < 10; i++)
      push(i[0], 32'hA0000000 + i, i < 9);
    chk("t4_level", fifo_level, 4'd8);
    chk("t4_ovf", overflow, 1'b1);
    @(negedge clk);
    new_result  = 1'b1;
    result_data = 32'hBAD0BAD0;
    clear_ovf   = 1'b1;
    @(negedge clk);
    new_result = 1'b0;
    clear_ovf  = 1'b0;
    chk("t4_set_wins", overflow, 1'b1);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    chk("t4_cleared", overflow, 1'b0);
    tx_busy = 1'b0;
    wait_drain("t4", 300);
    chk("t4_level_end", fifo_level, 4'd0);

    // 5: reset in the middle of a frame
    tx_busy = 1'b1;
    push(1'b0, 32'h12345678, 1'b1);
    push(1'b0, 32'h87654321, 1'b1);
    tx_busy = 1'b0;
    wait_strobes("t5", 2);
    rst = 1'b1;
    @(posedge clk);
    #1 exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("t5_new_tx", new_tx_data, 1'b0);
    chk("t5_level", fifo_level, 4'd0);
    s0 = n_strobe;
    repeat (40) @(negedge clk);
    chk("t5_silent", n_strobe - s0, 0);

    // 6: push into a full FIFO in the cycle the FSM pops
    tx_busy = 1'b1;
    push(1'b1, 32'hC0DE0000, 1'b1);
    for (int i = 1; i <= 8; i++)
      push(1'b0, 32'hC0DE0000 + i, 1'b1);
    chk("t6_full", fifo_level, 4'd8);
    tx_busy = 1'b0;
    wait_strobes("t6", 5);
    @(negedge clk);
    new_result  = 1'b1;
    result_done = 1'b1;
    result_data = 32'hC0DE0009;
    expect_frame(1'b1, 32'hC0DE0009);
    @(negedge clk);
    new_result = 1'b0;
    chk("t6_level", fifo_level, 4'd8);
    chk("t6_ovf", overflow, 1'b0);
    wait_drain("t6", 300);
    chk("t6_level_end", fifo_level, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
